uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
UART transmitter, serialising one parallel word per frame onto the tx line: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits. Bit timing comes from the shared 16x oversampling tick (sam_tick) produced by the baud generator that also feeds the receiver. Sits between the host-side write logic and the tx pin, as the counterpart of the receiver FSM.

Parameters:
DATA_BITS, 8, payload bits per frame (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY, 1, 0 = none, 1 = odd, 2 = even
OVERSAMPLE, 16, sam_ticks per bit period

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
sam_tick  input  1  one-clk-wide oversample strobe, OVERSAMPLE per bit
tx_start  input  1  request to send tx_data; sampled only in IDLE
tx_data  input  DATA_BITS  word to send; latched on accepted tx_start
tx  output  1  serial line, idle high
tx_busy  output  1  high from the cycle after acceptance until frame end
tx_done  output  1  one-clk pulse at frame end

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: tx = 1, tx_busy = 0, tx_done = 0, state = IDLE, all counters 0. tx is a registered output with no glitches.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: tx = 1. If tx_start = 1 at a clk edge:
  - latch tx_data into the shift register;
  - compute the parity bit (odd: ~^tx_data; even: ^tx_data);
  - clear s_count; go to START.
  - Next cycle: tx = 0, tx_busy = 1.
- START: tx = 0 for OVERSAMPLE sam_ticks. s_count increments on each sam_tick. On the edge where sam_tick = 1 and s_count = OVERSAMPLE-1: clear s_count and b_count, go to DATA.
- DATA: tx = shift_reg[0].
  - At each bit end (sam_tick with s_count = OVERSAMPLE-1), shift right.
  - If b_count = DATA_BITS-1: go to PAR, or to STOP when PARITY = 0. Otherwise increment b_count.
- PAR: tx = parity bit for one bit period, then go to STOP.
- STOP: tx = 1 for OVERSAMPLE*STOP_BITS sam_ticks. s_count must be wide enough for 31. At the end: go to IDLE, tx_busy = 0, tx_done = 1 for exactly one clk.
- Counters advance only on clk edges with sam_tick = 1. With no ticks, the FSM holds its state.
- tx_start while tx_busy = 1 is ignored: no queueing, and tx_data changes do not affect the frame in flight.
- Back-to-back frames: tx_start asserted in the cycle tx_done = 1 (state already IDLE) is accepted. The next start bit begins on the following cycle, with no extra idle bit-time.
- A tick in the same cycle as acceptance is not counted. The start bit counts from the first tick after entry to START.
- reset_n low mid-frame: tx returns to 1 immediately (asynchronously), the frame is abandoned and tx_done is not pulsed.
- Illegal PARITY value (3) behaves as 0.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input tx_break (1 bit).
  - When tx_break = 1 in IDLE: tx is driven 0, tx_busy = 1, and tx_start is ignored.
  - When tx_break falls: tx = 1 for one full bit period (OVERSAMPLE ticks) of mark before IDLE accepts tx_start. tx_done is not pulsed for a break.
  - tx_break asserted mid-frame is ignored until IDLE.
- Undefined: no tx_break port and no break logic. Behaviour is exactly as above.

Test Plan:
- Reset with reset_n = 0, no ticks -> tx = 1, tx_busy = 0, tx_done = 0. Release reset_n with tx_start = 0 for 100 clk -> outputs unchanged.
- Defaults, sam_tick every 4 clk, tx_data = 8'h55, 1-clk tx_start -> tx = 0,1,0,1,0,1,0,1,0, parity 1, stop 1, each bit 64 clk. tx_busy high 704 clk, then a single tx_done pulse.
- PARITY = 2, tx_data = 8'hA3 -> data bits 1,1,0,0,0,1,0,1, then parity bit 0. Frame length 11 bit-times.
- PARITY = 0, STOP_BITS = 2, tx_data = 8'hFF -> start 0, eight 1s, stop high for 32 ticks, no parity bit. tx_done after 176 ticks. tx_start held high during the frame with tx_data = 8'h00 -> ignored.
- Back-to-back: tx_start for 8'h01 asserted in the tx_done cycle of the prior frame -> tx falls to 0 on the next clk, and the second frame is correct.
- reset_n pulsed low mid-DATA -> tx = 1 within the same cycle, no tx_done. A fresh 8'h3C frame afterwards is correct.
- With UART_TX_BREAK_EN: tx_break high for 200 ticks -> tx = 0 throughout. After release, tx = 1 for 16 ticks, then tx_start is accepted.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits, timed by sam_tick.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN (adds input tx_break).
module uart_tx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sam_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam bit HAS_PAR    = (PARITY == 1) || (PARITY == 2);
  localparam int STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int SW         = (STOP_TICKS > 32) ? $clog2(STOP_TICKS) : 5;
  localparam int BW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] ST_BRK   = 3'd5;
  localparam logic [2:0] ST_MARK  = 3'd6;
`endif

  logic [2:0]           state;
  logic [SW-1:0]        s_count;
  logic [BW-1:0]        b_count;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 bit_end;

  assign bit_end = sam_tick && (s_count == BIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      s_count   <= '0;
      b_count   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (tx_break) begin
            state   <= ST_BRK;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end else
`endif
          if (tx_start) begin
            shift_reg <= tx_data;
            par_bit   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            s_count   <= '0;
            state     <= ST_START;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            s_count <= '0;
            b_count <= '0;
            state   <= ST_DATA;
            tx      <= shift_reg[0];
          end else if (sam_tick) begin
            s_count <= s_count + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            s_count   <= '0;
            shift_reg <= shift_reg >> 1;
            if (b_count == DATA_LAST) begin
              // Parity slot is skipped entirely for PARITY 0 and the illegal value 3.
              if (HAS_PAR) begin
                state <= ST_PAR;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              b_count <= b_count + 1'b1;
              tx      <= shift_reg[1];
            end
          end else if (sam_tick) begin
            s_count <= s_count + 1'b1;
          end
        end
        ST_PAR: begin
          if (bit_end) begin
            s_count <= '0;
            state   <= ST_STOP;
            tx      <= 1'b1;
          end else if (sam_tick) begin
            s_count <= s_count + 1'b1;
          end
        end
        ST_STOP: begin
          if (sam_tick && (s_count == STOP_LAST)) begin
            s_count <= '0;
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else if (sam_tick) begin
            s_count <= s_count + 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BRK: begin
          if (!tx_break) begin
            s_count <= '0;
            state   <= ST_MARK;
            tx      <= 1'b1;
          end
        end
        ST_MARK: begin
          // One bit-time of mark after a break; no tx_done for breaks.
          if (bit_end) begin
            s_count <= '0;
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end else if (sam_tick) begin
            s_count <= s_count + 1'b1;
          end
        end
`endif
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: three parameterisations checked against a bit-list frame model.
module tb_uart_tx_fsm;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sam_tick = 1'b0;
  logic [2:0] start;
  logic [7:0] data [3];
  wire  [2:0] tx_w, busy_w, done_w;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  int par_cfg  [3] = '{1, 2, 0};
  int stop_cfg [3] = '{1, 1, 2};
  int tick_mode = 2;
  int tick_div  = 0;
  int total = 0;
  int bad   = 0;
  logic exp_bits [$];

  always #5 clk = ~clk;

  // mode 0: tick every 4 clk, 1: random ticks, 2: no ticks
  always @(posedge clk) begin
    #1;
    if (tick_mode == 0) begin
      tick_div = (tick_div + 1) % 4;
      sam_tick = (tick_div == 0);
    end else if (tick_mode == 1) begin
      sam_tick = ($urandom_range(0, 2) == 0);
    end else begin
      sam_tick = 1'b0;
    end
  end

  uart_tx_fsm #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .OVERSAMPLE(OS)) d0 (
    .clk(clk), .reset_n(reset_n), .sam_tick(sam_tick),
    .tx_start(start[0]), .tx_data(data[0]),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk),
`endif
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_fsm #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .OVERSAMPLE(OS)) d1 (
    .clk(clk), .reset_n(reset_n), .sam_tick(sam_tick),
    .tx_start(start[1]), .tx_data(data[1]),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_fsm #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(0), .OVERSAMPLE(OS)) d2 (
    .clk(clk), .reset_n(reset_n), .sam_tick(sam_tick),
    .tx_start(start[2]), .tx_data(data[2]),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    int n = 0;
    @(negedge clk);
    while (!sam_tick && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle_check(input int idx);
    @(negedge clk);
    chk("idle_done", done_w[idx], 1'b0);
    chk("idle_busy", busy_w[idx], 1'b0);
    chk("idle_tx", tx_w[idx], 1'b1);
  endtask

  // Caller is positioned at a negedge; the frame is accepted on the next posedge.
  task automatic run_frame(input int idx, input logic [7:0] d, input bit hold, input bit check_len);
    int nb;
    int ticks = 0;
    int cyc = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par_cfg[idx] == 1) exp_bits.push_back(~^d);
    else if (par_cfg[idx] == 2) exp_bits.push_back(^d);
    for (int i = 0; i < stop_cfg[idx]; i++) exp_bits.push_back(1'b1);
    nb = exp_bits.size();
    start[idx] = 1'b1;
    data[idx] = d;
    @(posedge clk);
    #1;
    if (hold) data[idx] = 8'h00;
    else start[idx] = 1'b0;
    while (ticks < nb * OS && cyc < 4000) begin
      @(negedge clk);
      chk("frame_tx", tx_w[idx], exp_bits[ticks / OS]);
      chk("frame_busy", busy_w[idx], 1'b1);
      chk("frame_done", done_w[idx], 1'b0);
      cyc++;
      if (sam_tick) ticks++;
      if (hold && ticks >= (nb - 1) * OS) start[idx] = 1'b0;
    end
    chk("frame_ticks", ticks, nb * OS);
    if (check_len) chk("busy_len", cyc, nb * OS * 4);
    @(negedge clk);
    chk("end_done", done_w[idx], 1'b1);
    chk("end_busy", busy_w[idx], 1'b0);
    chk("end_tx", tx_w[idx], 1'b1);
  endtask

  initial begin
    int ticks;
    int seen;
    int idx;
    logic [7:0] rd;
    reset_n = 1'b0;
    start = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", tx_w[i], 1'b1);
      chk("rst_busy", busy_w[i], 1'b0);
      chk("rst_done", done_w[i], 1'b0);
    end
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_tx", tx_w[i], 1'b1);
      chk("post_rst_busy", busy_w[i], 1'b0);
      chk("post_rst_done", done_w[i], 1'b0);
    end

    tick_mode = 0;
    align(); run_frame(0, 8'h55, 1'b0, 1'b1); idle_check(0);
    align(); run_frame(1, 8'hA3, 1'b0, 1'b1); idle_check(1);
    align(); run_frame(2, 8'hFF, 1'b1, 1'b1); idle_check(2);

    align(); run_frame(0, 8'hC4, 1'b0, 1'b1);
    run_frame(0, 8'h01, 1'b0, 1'b0);
    idle_check(0);

    // Abort a frame during DATA, then send a clean one.
    align();
    start[0] = 1'b1;
    data[0] = 8'hA5;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    ticks = 0;
    for (int n = 0; n < 1000 && ticks < OS * 2 + 3; n++) begin
      @(negedge clk);
      if (sam_tick) ticks++;
    end
    @(negedge clk);
    chk("pre_abort_tx", tx_w[0], 1'b0);
    reset_n = 1'b0;
    #1;
    chk("abort_tx", tx_w[0], 1'b1);
    chk("abort_busy", busy_w[0], 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) seen++;
    end
    chk("abort_no_done", seen, 0);
    align(); run_frame(0, 8'h3C, 1'b0, 1'b1); idle_check(0);

    tick_mode = 1;
    for (int k = 0; k < 6; k++) begin
      idx = $urandom_range(0, 2);
      rd = 8'($urandom);
      @(negedge clk);
      run_frame(idx, rd, 1'b0, 1'b0);
      idle_check(idx);
    end

`ifdef UART_TX_BREAK_EN
    tick_mode = 0;
    @(negedge clk);
    brk = 1'b1;
    start[0] = 1'b1;
    data[0] = 8'h00;
    ticks = 0;
    for (int n = 0; n < 4000 && ticks < 200; n++) begin
      @(negedge clk);
      chk("brk_tx", tx_w[0], 1'b0);
      chk("brk_busy", busy_w[0], 1'b1);
      if (sam_tick) ticks++;
    end
    chk("brk_ticks", ticks, 200);
    brk = 1'b0;
    start[0] = 1'b0;
    ticks = 0;
    for (int n = 0; n < 1000 && ticks < OS; n++) begin
      @(negedge clk);
      chk("mark_tx", tx_w[0], 1'b1);
      chk("mark_busy", busy_w[0], 1'b1);
      chk("mark_done", done_w[0], 1'b0);
      if (sam_tick) ticks++;
    end
    @(negedge clk);
    chk("post_mark_busy", busy_w[0], 1'b0);
    chk("post_mark_done", done_w[0], 1'b0);
    align(); run_frame(0, 8'h96, 1'b0, 1'b1); idle_check(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
